// File: rtl/cmd_physical_crc.sv
// rtl/cmd_physical_crc.sv - SD CMD-line physical layer: CRC7 framing, serial tx, timed rx with checks
module cmd_physical_crc #(
  parameter int LONG_W  = 136,
  parameter int SHORT_W = 48,
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              CLK_SD_card,
  input  logic              reset,
  input  logic              new_cmd,
  input  logic [37:0]       cmd_index_arg,
  input  logic [1:0]        resp_type,
  input  logic              REQ_in,
  input  logic              ACK_in,
  input  logic              cmd_from_sd,
  output logic              REQ_out,
  output logic              ACK_out,
  output logic [LONG_W-1:0] cmd_response,
  output logic              cmd_to_sd,
  output logic              cmd_to_sd_oe,
  output logic              timeout_error,
  output logic              crc_error,
  output logic              end_bit_error,
  output logic              physical_inactive
);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, NCC, WAIT, RECV, RETURN} state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_t             state;
  logic [46:0]        tx_sr;
  logic [LONG_W-2:0]  rx_sr;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         rx_crc;
  logic [1:0]         rtype;

  logic [39:0]        hdr;
  logic [6:0]         tx_crc;
  logic               long_sel;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   rx_w;
  logic [LONG_W-1:0]  rx_next;
  logic               crc_bit_en;
  logic               rx_done;
  logic               tbit;

  assign hdr = {2'b01, cmd_index_arg};

  always_comb begin
    tx_crc = '0;
    for (int i = 39; i >= 0; i--) tx_crc = crc7_step(tx_crc, hdr[i]);
  end

  assign long_sel = (rtype == 2'b10);
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign rx_w     = long_sel ? CNT_W'(LONG_W) : CNT_W'(SHORT_W);
  assign rx_next  = {rx_sr, cmd_from_sd};
  assign rx_done  = (cnt_inc == rx_w);
  assign tbit     = long_sel ? rx_next[LONG_W-2] : rx_next[SHORT_W-2];
  // Long responses exclude the 8 header bits from the CRC; short ones cover everything before the CRC.
  assign crc_bit_en = long_sel ? (cnt >= CNT_W'(8) && cnt < CNT_W'(LONG_W-8))
                               : (cnt < CNT_W'(SHORT_W-8));

  always_ff @(posedge CLK_SD_card) begin
    if (reset) begin
      state             <= IDLE;
      REQ_out           <= 1'b0;
      ACK_out           <= 1'b0;
      cmd_response      <= '0;
      cmd_to_sd         <= 1'b1;
      cmd_to_sd_oe      <= 1'b0;
      timeout_error     <= 1'b0;
      crc_error         <= 1'b0;
      end_bit_error     <= 1'b0;
      physical_inactive <= 1'b1;
      tx_sr             <= '0;
      rx_sr             <= '0;
      cnt               <= '0;
      rx_crc            <= '0;
      rtype             <= '0;
    end else begin
      ACK_out <= 1'b0;
      case (state)
        IDLE: if (new_cmd) begin
          state             <= SETUP;
          physical_inactive <= 1'b0;
        end
        SETUP: if (REQ_in) begin
          rtype         <= resp_type;
          tx_sr         <= {hdr[38:0], tx_crc, 1'b1};
          cmd_to_sd     <= hdr[39];
          cmd_to_sd_oe  <= 1'b1;
          cnt           <= CNT_W'(1);
          timeout_error <= 1'b0;
          crc_error     <= 1'b0;
          end_bit_error <= 1'b0;
          ACK_out       <= 1'b1;
          state         <= SEND;
        end
        SEND: if (cnt == CNT_W'(SHORT_W)) begin
          cmd_to_sd    <= 1'b1;
          cmd_to_sd_oe <= 1'b0;
          cnt          <= '0;
          state        <= (rtype == 2'b00) ? NCC : WAIT;
        end else begin
          cmd_to_sd <= tx_sr[46];
          tx_sr     <= {tx_sr[45:0], 1'b1};
          cnt       <= cnt_inc;
        end
        NCC: if (cnt == CNT_W'(NCC_MIN-1)) begin
          cnt               <= '0;
          state             <= IDLE;
          physical_inactive <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
        WAIT: if (!cmd_from_sd) begin
          rx_sr  <= '0;
          rx_crc <= '0;
          cnt    <= CNT_W'(1);
          state  <= RECV;
        end else if (cnt == CNT_W'(NCR_MAX-1)) begin
          timeout_error     <= 1'b1;
          cnt               <= '0;
          state             <= IDLE;
          physical_inactive <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
        RECV: begin
          rx_sr <= rx_next[LONG_W-2:0];
          cnt   <= cnt_inc;
          if (crc_bit_en) rx_crc <= crc7_step(rx_crc, cmd_from_sd);
          if (rx_done) begin
            cmd_response <= rx_next;
            REQ_out      <= 1'b1;
            cnt          <= '0;
            state        <= RETURN;
            if (tbit || !cmd_from_sd) end_bit_error <= 1'b1;
            if (rtype != 2'b11 && rx_next[7:1] != rx_crc) crc_error <= 1'b1;
          end
        end
        RETURN: if (ACK_in) begin
          REQ_out           <= 1'b0;
          state             <= IDLE;
          physical_inactive <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_physical_crc.sv
// tb/tb_cmd_physical_crc.sv - scoreboard bench for cmd_physical_crc
module tb_cmd_physical_crc;

  logic         clk = 1'b0;
  logic         reset, new_cmd, REQ_in, ACK_in, cmd_from_sd;
  logic [37:0]  cmd_index_arg;
  logic [1:0]   resp_type;
  logic         REQ_out, ACK_out, cmd_to_sd, cmd_to_sd_oe;
  logic [135:0] cmd_response;
  logic         timeout_error, crc_error, end_bit_error, physical_inactive;

  always #5 clk = ~clk;

  cmd_physical_crc dut (
    .CLK_SD_card(clk), .reset(reset), .new_cmd(new_cmd), .cmd_index_arg(cmd_index_arg),
    .resp_type(resp_type), .REQ_in(REQ_in), .ACK_in(ACK_in), .cmd_from_sd(cmd_from_sd),
    .REQ_out(REQ_out), .ACK_out(ACK_out), .cmd_response(cmd_response), .cmd_to_sd(cmd_to_sd),
    .cmd_to_sd_oe(cmd_to_sd_oe), .timeout_error(timeout_error), .crc_error(crc_error),
    .end_bit_error(end_bit_error), .physical_inactive(physical_inactive)
  );

  typedef struct {
    logic [135:0] resp;
    logic [2:0]   flags;
  } exp_t;

  exp_t        rq[$];
  logic [47:0] txq[$];
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [47:0] F_CMD0 = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8 = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD2 = 48'h42_0000_0000_4D;
  localparam logic [47:0] R_CMD8 = 48'h08_0000_01AA_13;
  localparam logic [47:0] R3_BAD = 48'h3F_00FF_8000_FE;
  localparam logic [119:0] CID   = 120'h03_5344_5344_3332_3080_1234_5678_0100;

  logic [135:0] long_good, long_bad;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] tb_crc7(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      logic f;
      f = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (f) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Transmit monitor: collects each oe-high burst and compares against the next expected frame.
  initial begin
    logic [47:0] sr;
    int c;
    sr = '0;
    c = 0;
    forever begin
      @(negedge clk);
      if (cmd_to_sd_oe) begin
        sr = {sr[46:0], cmd_to_sd};
        c++;
      end else if (c > 0) begin
        if (txq.size() > 0) begin
          logic [47:0] e;
          e = txq.pop_front();
          check("tx_len", c, 48);
          check("tx_frame", sr, e);
        end
        c = 0;
      end
    end
  end

  // Response monitor: each rising REQ_out must match the oldest expected response.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (REQ_out && !prev) begin
        if (rq.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          exp_t e;
          e = rq.pop_front();
          check("resp_data", cmd_response, e.resp);
          check("resp_flags", {timeout_error, crc_error, end_bit_error}, e.flags);
        end
      end
      prev = REQ_out;
    end
  end

  task automatic send_cmd(input logic [37:0] ia, input logic [1:0] rt, input logic [47:0] frame,
                          input bit expect_tx);
    int k;
    if (expect_tx) txq.push_back(frame);
    @(negedge clk);
    cmd_index_arg = ia;
    resp_type = rt;
    new_cmd = 1'b1;
    @(negedge clk);
    new_cmd = 1'b0;
    REQ_in = 1'b1;
    k = 0;
    while (!ACK_out && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ack_seen", ACK_out, 1);
    REQ_in = 1'b0;
    @(negedge clk);
    check("ack_pulse", ACK_out, 0);
  endtask

  task automatic wait_tx_end();
    int k;
    k = 0;
    while (cmd_to_sd_oe && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("tx_end", cmd_to_sd_oe, 0);
  endtask

  task automatic drive_resp(input logic [135:0] bits, input int w, input int nbits, input int dly);
    repeat (dly) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cmd_from_sd = bits[w-1-i];
      @(negedge clk);
    end
    cmd_from_sd = 1'b1;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (!physical_inactive && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("reach_idle", physical_inactive, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_inactive"}, physical_inactive, 1);
    check({tag, "_oe"}, cmd_to_sd_oe, 0);
    check({tag, "_line"}, cmd_to_sd, 1);
    check({tag, "_flags"}, {timeout_error, crc_error, end_bit_error}, 0);
    check({tag, "_req"}, {REQ_out, ACK_out}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    long_good = {8'h3F, CID, tb_crc7(CID), 1'b1};
    long_bad  = long_good ^ (136'h1 << 3);
    reset = 1'b1; new_cmd = 1'b0; REQ_in = 1'b0; ACK_in = 1'b1; cmd_from_sd = 1'b1;
    cmd_index_arg = '0; resp_type = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    check("por_resp", cmd_response, 0);
    reset = 1'b0;

    // CMD0, no response: NCC gap then IDLE
    send_cmd({6'd0, 32'h0}, 2'b00, F_CMD0, 1'b1);
    wait_tx_end();
    k = 0;
    while (!physical_inactive && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ncc_len", k, 8);

    // CMD8 with a valid R7
    rq.push_back('{resp: {88'h0, R_CMD8}, flags: 3'b000});
    send_cmd({6'd8, 32'h1AA}, 2'b01, F_CMD8, 1'b1);
    wait_tx_end();
    drive_resp({88'h0, R_CMD8}, 48, 48, 5);
    wait_idle(20);

    // No response: timeout exactly NCR_MAX cycles after the last tx bit
    send_cmd({6'd8, 32'h1AA}, 2'b01, F_CMD8, 1'b1);
    wait_tx_end();
    k = 0;
    while (!timeout_error && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 64);
    check("timeout_idle", physical_inactive, 1);
    check("timeout_noreq", REQ_out, 0);

    // Long R2: clean, then one CRC bit flipped
    rq.push_back('{resp: long_good, flags: 3'b000});
    send_cmd({6'd2, 32'h0}, 2'b10, F_CMD2, 1'b1);
    wait_tx_end();
    drive_resp(long_good, 136, 136, 2);
    wait_idle(20);

    rq.push_back('{resp: long_bad, flags: 3'b010});
    send_cmd({6'd2, 32'h0}, 2'b10, F_CMD2, 1'b1);
    wait_tx_end();
    drive_resp(long_bad, 136, 136, 0);
    wait_idle(20);

    // R3-style (no CRC) with a zero end bit
    rq.push_back('{resp: {88'h0, R3_BAD}, flags: 3'b001});
    send_cmd({6'd0, 32'h0}, 2'b11, F_CMD0, 1'b1);
    wait_tx_end();
    drive_resp({88'h0, R3_BAD}, 48, 48, 10);
    wait_idle(20);

    // Reset during transmit, then a clean CMD0
    send_cmd({6'd0, 32'h0}, 2'b00, F_CMD0, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("txrst");
    reset = 1'b0;
    send_cmd({6'd0, 32'h0}, 2'b00, F_CMD0, 1'b1);
    wait_tx_end();
    wait_idle(20);

    // Reset during receive, then a clean CMD0
    send_cmd({6'd2, 32'h0}, 2'b10, F_CMD2, 1'b1);
    wait_tx_end();
    drive_resp(long_good, 136, 60, 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rxrst");
    check("rxrst_resp", cmd_response, 0);
    reset = 1'b0;
    send_cmd({6'd0, 32'h0}, 2'b00, F_CMD0, 1'b1);
    wait_tx_end();
    wait_idle(20);

    // RETURN hold with ACK_in low; new_cmd pulses must be ignored
    ACK_in = 1'b0;
    rq.push_back('{resp: {88'h0, R_CMD8}, flags: 3'b000});
    send_cmd({6'd8, 32'h1AA}, 2'b01, F_CMD8, 1'b1);
    wait_tx_end();
    drive_resp({88'h0, R_CMD8}, 48, 48, 4);
    k = 0;
    while (!REQ_out && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      new_cmd = (i % 3 == 0);
      @(negedge clk);
      check("hold_req", REQ_out, 1);
      check("hold_resp", cmd_response, {88'h0, R_CMD8});
    end
    new_cmd = 1'b0;
    ACK_in = 1'b1;
    @(negedge clk);
    check("ack_release_req", REQ_out, 0);
    check("ack_release_idle", physical_inactive, 1);
    @(negedge clk);
    check("new_cmd_ignored", physical_inactive, 1);

    repeat (5) @(negedge clk);
    check("rq_drained", rq.size(), 0);
    check("txq_drained", txq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
